// File: rtl/breath_pkg.sv
// Shared definitions for the breathing duty sequencer.
// Phase encoding and a constant clog2 helper.
package breath_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } phase_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// Modulo-N counter of qualified strobes.
// Sync clear beats increment; tc flags the last count.
module strobe_div
    import breath_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/breath_duty_gen.sv
// Breathing duty ramp for the PWM stage: rise, hold, fall, hold.
// Duty only moves on the PWM end-of-period strobe.
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int CYCLE        = 12,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 8,
    localparam int DUTY_W      = clog2(CYCLE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [2:0]        phase
);

    localparam int CNT_LOG = clog2(imax(STEP_PERIODS, HOLD_PERIODS));
    localparam int CNT_W   = (CNT_LOG > 0) ? CNT_LOG : 1;

    phase_t st;
    logic   qual;
    logic   step_tc;
    logic   hold_tc;
    logic   step_clr;
    logic   step_inc;
    logic   hold_clr;
    logic   hold_inc;
    logic   at_top;
    logic   at_bot;
    logic   in_hold;
    logic   in_ramp;

    assign qual    = en && period_end;
    assign at_top  = (duty == DUTY_W'(CYCLE - 1));
    assign at_bot  = (duty == DUTY_W'(1));
    assign in_hold = (st == HOLD_HI) || (st == HOLD_LO);
    assign in_ramp = (st == RISE) || (st == FALL);

    // Step counter restarts on every entry into a ramp phase
    assign step_clr = restart ||
                      (qual && ((st == IDLE) || (in_hold && hold_tc)));
    assign step_inc = qual && in_ramp;

    assign hold_clr = restart ||
                      (qual && step_tc &&
                       (((st == RISE) && at_top) ||
                        ((st == FALL) && at_bot)));
    assign hold_inc = qual && in_hold;

    strobe_div #(
        .N (STEP_PERIODS),
        .W (CNT_W)
    ) u_step (
        .clk (clk),
        .rst (rst),
        .clr (step_clr),
        .inc (step_inc),
        .tc  (step_tc)
    );

    strobe_div #(
        .N (HOLD_PERIODS),
        .W (CNT_W)
    ) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .inc (hold_inc),
        .tc  (hold_tc)
    );

    assign phase = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            duty     <= '0;
            duty_upd <= 1'b0;
        end else begin
            duty_upd <= 1'b0;
            if (restart) begin
                st       <= IDLE;
                duty     <= '0;
                duty_upd <= (duty != '0);
            end else if (qual) begin
                unique case (st)
                    IDLE: st <= RISE;
                    RISE: begin
                        if (step_tc) begin
                            duty     <= duty + DUTY_W'(1);
                            duty_upd <= 1'b1;
                            if (at_top) st <= HOLD_HI;
                        end
                    end
                    HOLD_HI: if (hold_tc) st <= FALL;
                    FALL: begin
                        if (step_tc) begin
                            duty     <= duty - DUTY_W'(1);
                            duty_upd <= 1'b1;
                            if (at_bot) st <= HOLD_LO;
                        end
                    end
                    HOLD_LO: if (hold_tc) st <= RISE;
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/breath_duty_gen.md
Name: breath_duty_gen

Overview:
- Upstream duty-cycle sequencer for the PWM output stage. It produces a "breathing" duty ramp in four phases: rise, hold high, fall, hold low.
- It consumes the PWM stage's end-of-period strobe and changes duty only on that strobe, so the PWM compare never sees a mid-period update.
- Its output drives the PWM stage's duty input directly; both run on the same clock.

Parameters:
- CYCLE, 12: PWM period in clocks; also the maximum duty (full on).
- STEP_PERIODS, 4: number of PWM periods per ±1 duty step during rise and fall; must be ≥1.
- HOLD_PERIODS, 8: number of PWM periods spent in each hold phase; must be ≥1.
- DUTY_W, derived localparam = clog2(CYCLE+1): duty width (4 at the default).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  run enable; low freezes all state.
- restart  in  1  synchronous clear to IDLE; one-cycle pulse or level.
- period_end  in  1  one-cycle strobe from the PWM stage on the last count of each period (count==CYCLE-1).
- duty  out  DUTY_W  current duty, 0..CYCLE; registered.
- duty_upd  out  1  one-cycle pulse in the first cycle duty shows a new value.
- phase  out  3  current state encoding, for debug/LED status.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- rst asserted: immediately (no clock edge needed) duty=0, duty_upd=0, phase=IDLE, step/hold counters=0.
- Every update takes effect on the clk edge at which period_end=1. duty and duty_upd change together. Latency from the period_end edge is 0 cycles.
- Priority each cycle: rst > restart > (en && period_end) > hold.
- restart=1: next edge gives phase=IDLE, duty=0, counters=0. duty_upd=1 only if duty was nonzero. A simultaneous period_end is ignored.
- en=0: duty, phase and counters all hold; period_end is ignored; duty_upd=0.
- The counters count only qualified strobes (en && period_end), never raw clocks.
- State transitions (all evaluated on a qualified strobe only):
  - IDLE: go to RISE; step_cnt=0; duty unchanged (0).
  - RISE: if step_cnt==STEP_PERIODS-1 then step_cnt=0, duty=duty+1, duty_upd=1. If the new duty==CYCLE, go to HOLD_HI with hold_cnt=0. Otherwise step_cnt+1.
  - HOLD_HI: if hold_cnt==HOLD_PERIODS-1 then go to FALL with step_cnt=0. Otherwise hold_cnt+1. duty stays CYCLE.
  - FALL: mirror of RISE with duty-1. When the new duty==0, go to HOLD_LO with hold_cnt=0.
  - HOLD_LO: if hold_cnt==HOLD_PERIODS-1 then go to RISE with step_cnt=0. Otherwise hold_cnt+1.
- Bounds: duty never exceeds CYCLE and never underflows below 0; the transitions guarantee this, and the bench asserts it.
- Phase lengths in strobes:
  - IDLE: 1.
  - RISE: CYCLE·STEP_PERIODS.
  - HOLD_HI: HOLD_PERIODS.
  - FALL: CYCLE·STEP_PERIODS.
  - HOLD_LO: HOLD_PERIODS.
  - Steady loop = 2·CYCLE·STEP_PERIODS + 2·HOLD_PERIODS strobes (112 at defaults).
- Counter widths: clog2(max(STEP_PERIODS,HOLD_PERIODS)); counters wrap only via the explicit clears above.
- duty_upd: exactly one pulse per duty change, never asserted when duty is unchanged.
- Reset mid-operation (any phase): the async clear above, after which the sequence restarts from IDLE.

Decomposition:
- Shared package breath_pkg:
  - phase encoding constants: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4 (3-bit).
  - a clog2 function used to derive DUTY_W.
- One natural sub-module, strobe_div: a modulo-N counter of qualified strobes with sync clear and a terminal-count output.
  - Instantiated twice: one for step_cnt (N=STEP_PERIODS), one for hold_cnt (N=HOLD_PERIODS).
- The FSM plus the duty register stay in breath_duty_gen.

Test Plan (defaults; period_end pulsed every 12 clocks, as the PWM stage does):
- Reset: assert rst between edges → duty=0, phase=0 and duty_upd=0 immediately. Hold rst 5 cycles → outputs stay the same.
- Rise ramp: en=1.
  - 1st strobe → phase=RISE, duty=0.
  - 4 more strobes → duty=1 with a single duty_upd pulse.
  - 48 strobes after entering RISE → duty=12, phase=HOLD_HI, exactly 12 duty_upd pulses.
- Full loop: continue.
  - 8 strobes → FALL.
  - 48 strobes → duty=0, HOLD_LO.
  - 8 strobes → RISE.
  - Check the loop is 112 strobes, duty stays within 0..12 throughout, and duty changes only on period_end edges.
- Freeze: at RISE with duty=5 and step_cnt=2, drop en for 20 strobes → duty=5, phase and counters unchanged, no duty_upd. Re-raise en → duty=6 after 2 more strobes.
- Restart collision: at FALL with duty=7, assert restart in the same cycle as period_end → next edge duty=0, phase=IDLE, one duty_upd pulse. The next qualified strobe → RISE.
- Async reset mid-HOLD_HI: pulse rst for a half-cycle away from clk edges → duty drops to 0 with no clock edge. After release, the sequence restarts from IDLE exactly as in the Rise ramp scenario.
